// File: rtl/lane_gather_fifo.sv
// Packs LANE_W-bit elements into N_LANES-wide rows and queues completed rows in a DEPTH-row fall-through FIFO.
// Defining LANE_GATHER_FIFO_LEVEL_EN adds the level and gather_busy status outputs.
module lane_gather_fifo #(
    parameter int LANE_W  = 4,
    parameter int N_LANES = 2,
    parameter int DEPTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANE_W-1:0]                 in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_LANES*LANE_W-1:0]         out_data,
`ifdef LANE_GATHER_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH+1)-1:0]        level,
    output logic                              gather_busy,
`endif
    output logic [$clog2(N_LANES+1)-1:0]      out_lanes
);

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LN_W  = $clog2(N_LANES + 1);

    logic [N_LANES-1:0][LANE_W-1:0]            gather;
    logic [N_LANES-1:0][LANE_W-1:0]            row_next;
    logic [IDX_W-1:0]                          lane_idx;
    logic [DEPTH-1:0][N_LANES-1:0][LANE_W-1:0] mem;
    logic [DEPTH-1:0][LN_W-1:0]                lanes_mem;
    logic [PTR_W-1:0]                          rd_ptr;
    logic [PTR_W-1:0]                          wr_ptr;
    logic [CNT_W-1:0]                          count;
    logic                                      accept;
    logic                                      complete;
    logic                                      pop;
    logic                                      last_lane;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign last_lane = (lane_idx == IDX_W'(N_LANES - 1));
    assign complete  = accept && (last_lane || in_last);

    assign out_data  = mem[rd_ptr];
    assign out_lanes = lanes_mem[rd_ptr];

`ifdef LANE_GATHER_FIFO_LEVEL_EN
    assign level       = count;
    assign gather_busy = (lane_idx != '0);
`endif

    // Lanes above lane_idx are already zero because the gather row clears after every push.
    always_comb begin
        row_next           = gather;
        row_next[lane_idx] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gather   <= '0;
            lane_idx <= '0;
        end else if (accept) begin
            if (complete) begin
                gather   <= '0;
                lane_idx <= '0;
            end else begin
                gather[lane_idx] <= in_data;
                lane_idx         <= lane_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem       <= '0;
            lanes_mem <= '0;
            wr_ptr    <= '0;
        end else if (complete) begin
            mem[wr_ptr]       <= row_next;
            lanes_mem[wr_ptr] <= LN_W'(lane_idx) + LN_W'(1);
            wr_ptr            <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({complete, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_gather_fifo.sv
// Directed bench for lane_gather_fifo: a default 4x2x2 instance and a wide 8x4x3 instance.
// Level/gather_busy checks are compiled in when LANE_GATHER_FIFO_LEVEL_EN is defined.
module tb_lane_gather_fifo;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [3:0]  in_data;
    logic [7:0]  out_data;
    logic [1:0]  out_lanes;

    logic        in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b;
    logic [7:0]  in_data_b;
    logic [31:0] out_data_b;
    logic [2:0]  out_lanes_b;

`ifdef LANE_GATHER_FIFO_LEVEL_EN
    logic [1:0]  level, level_b;
    logic        gather_busy, gather_busy_b;
`endif

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    lane_gather_fifo #(.LANE_W(4), .N_LANES(2), .DEPTH(2)) dutSmall (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        .level(level), .gather_busy(gather_busy),
`endif
        .out_lanes(out_lanes)
    );

    lane_gather_fifo #(.LANE_W(8), .N_LANES(4), .DEPTH(3)) dutWide (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_last(in_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        .level(level_b), .gather_busy(gather_busy_b),
`endif
        .out_lanes(out_lanes_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle on the small instance; returns #1 after the rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusWide(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid_b  = v;
        in_data_b   = d;
        in_last_b   = l;
        out_ready_b = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e, k, mcnt;
        logic orr, push, pop;
        logic [7:0] expRow;

        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        in_valid_b = 0; in_data_b = 0; in_last_b = 0; out_ready_b = 0;
        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_lanes", out_lanes, 0);
        checkOutput("rst_in_ready", in_ready, 1);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("rst_level", level, 0);
        checkOutput("rst_gather_busy", gather_busy, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] full row with immediate pop");
        applyStimulus(1, 4'h3, 0, 1);
        checkOutput("s1_not_yet_valid", out_valid, 0);
        applyStimulus(1, 4'hA, 0, 1);
        checkOutput("s1_out_valid", out_valid, 1);
        checkOutput("s1_out_data", out_data, 8'hA3);
        checkOutput("s1_out_lanes", out_lanes, 2);
        applyStimulus(0, 4'h0, 0, 1);
        checkOutput("s1_drained", out_valid, 0);

        $display("[TB] partial row via in_last");
        applyStimulus(1, 4'h5, 1, 1);
        checkOutput("s2_out_data", out_data, 8'h05);
        checkOutput("s2_out_lanes", out_lanes, 1);
        applyStimulus(0, 4'h0, 0, 1);
        checkOutput("s2_drained", out_valid, 0);
        applyStimulus(1, 4'h6, 0, 1);
        checkOutput("s2_restart_wait", out_valid, 0);
        applyStimulus(1, 4'h7, 0, 1);
        checkOutput("s2_restart_data", out_data, 8'h76);
        checkOutput("s2_restart_lanes", out_lanes, 2);
        applyStimulus(0, 4'h0, 0, 1);

        $display("[TB] fill to full and backpressure");
        applyStimulus(1, 4'h1, 0, 0);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("s3_busy_mid", gather_busy, 1);
        checkOutput("s3_level0", level, 0);
`endif
        applyStimulus(1, 4'h2, 0, 0);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("s3_busy_clear", gather_busy, 0);
        checkOutput("s3_level1", level, 1);
`endif
        checkOutput("s3_in_ready_one_row", in_ready, 1);
        applyStimulus(1, 4'h3, 0, 0);
        applyStimulus(1, 4'h4, 0, 0);
        checkOutput("s3_full_in_ready", in_ready, 0);
        checkOutput("s3_full_head", out_data, 8'h21);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("s3_level2", level, 2);
`endif
        applyStimulus(1, 4'h5, 0, 0);
        checkOutput("s3_held_in_ready", in_ready, 0);
        checkOutput("s3_held_head", out_data, 8'h21);
        applyStimulus(0, 4'h0, 0, 1);
        checkOutput("s3_pop_in_ready", in_ready, 1);
        checkOutput("s3_next_head", out_data, 8'h43);
        checkOutput("s3_next_lanes", out_lanes, 2);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("s3_level_pop1", level, 1);
`endif
        applyStimulus(0, 4'h0, 0, 1);
        checkOutput("s3_empty", out_valid, 0);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("s3_level_pop2", level, 0);
`endif
        applyStimulus(1, 4'h6, 1, 0);
        checkOutput("s3_refused_not_gathered", out_data, 8'h06);
        checkOutput("s3_refused_lanes", out_lanes, 1);
        applyStimulus(0, 4'h0, 0, 1);

        $display("[TB] pointer wrap with toggling out_ready");
        e = 0; k = 0; mcnt = 0; orr = 1'b0;
        for (int cyc = 0; cyc < 100 && k < 8; cyc++) begin
            orr       = ~orr;
            out_ready = orr;
            in_valid  = (e < 16);
            in_data   = 4'(e);
            in_last   = 1'b0;
            checkOutput("wrap_in_ready", in_ready, (mcnt != 2));
            checkOutput("wrap_out_valid", out_valid, (mcnt != 0));
            push = in_valid && (mcnt != 2) && (e % 2 == 1);
            pop  = orr && (mcnt != 0);
            if (pop) begin
                expRow = 8'((2 * k + 1) * 16 + 2 * k);
                checkOutput("wrap_row", out_data, expRow);
                k++;
            end
            if (in_valid && mcnt != 2) e++;
            mcnt = mcnt + int'(push) - int'(pop);
            @(posedge clk);
            #1;
        end
        checkOutput("wrap_rows_seen", k, 8);
        checkOutput("wrap_final_empty", out_valid, 0);
        in_valid = 0;

        $display("[TB] asynchronous reset mid-gather");
        applyStimulus(1, 4'h1, 0, 0);
        applyStimulus(1, 4'h1, 0, 0);
        applyStimulus(1, 4'h7, 0, 0);
        checkOutput("ar_pre_valid", out_valid, 1);
        checkOutput("ar_pre_head", out_data, 8'h11);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_out_valid", out_valid, 0);
        checkOutput("ar_out_data", out_data, 0);
        checkOutput("ar_out_lanes", out_lanes, 0);
        checkOutput("ar_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 4'h1, 0, 0);
        applyStimulus(1, 4'h2, 0, 0);
        checkOutput("ar_after_head", out_data, 8'h21);
        checkOutput("ar_after_lanes", out_lanes, 2);
        applyStimulus(0, 4'h0, 0, 1);

        $display("[TB] wide instance");
        applyStimulusWide(1, 8'h11, 0, 1);
        applyStimulusWide(1, 8'h22, 0, 1);
        applyStimulusWide(1, 8'h33, 0, 1);
        checkOutput("w_not_yet_valid", out_valid_b, 0);
        applyStimulusWide(1, 8'h44, 0, 1);
        checkOutput("w_out_valid", out_valid_b, 1);
        checkOutput("w_out_data", out_data_b, 32'h44332211);
        checkOutput("w_out_lanes", out_lanes_b, 4);
        applyStimulusWide(0, 8'h00, 0, 1);
        checkOutput("w_drained", out_valid_b, 0);
        applyStimulusWide(1, 8'hAA, 0, 1);
        applyStimulusWide(1, 8'hBB, 1, 1);
        checkOutput("w_partial_data", out_data_b, 32'h0000BBAA);
        checkOutput("w_partial_lanes", out_lanes_b, 2);
        applyStimulusWide(0, 8'h00, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            applyStimulusWide(1, 8'(i), 0, 0);
        end
        checkOutput("w_full_in_ready", in_ready_b, 0);
        checkOutput("w_full_head", out_data_b, 32'h04030201);
`ifdef LANE_GATHER_FIFO_LEVEL_EN
        checkOutput("w_full_level", level_b, 3);
`endif
        applyStimulusWide(0, 8'h00, 0, 1);
        checkOutput("w_pop_in_ready", in_ready_b, 1);
        checkOutput("w_pop_head", out_data_b, 32'h08070605);
        checkOutput("w_pop_lanes", out_lanes_b, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
